// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with occupancy count, almost-full/almost-empty
// thresholds, sticky overflow/underflow flags, synchronous flush and an optional
// first-word-fall-through read port.
module sync_fifo_flags #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2,
    parameter int FWFT       = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     w_en,
    input  logic                     r_en,
    input  logic [DATA_WIDTH-1:0]    data_in,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [PW-1:0] AF_THR  = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_THR  = PW'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [AW-1:0]         wr_idx;
    logic [AW-1:0]         rd_idx;
    logic                  wr_accept;
    logic                  rd_accept;

    assign wr_idx = wr_ptr[AW-1:0];
    assign rd_idx = rd_ptr[AW-1:0];

    // Status flags and occupancy derived purely from the registered pointers.
    always_comb begin
        full         = (wr_idx == rd_idx) && (wr_ptr[AW] != rd_ptr[AW]);
        empty        = (wr_ptr == rd_ptr);
        count        = wr_ptr - rd_ptr;
        almost_full  = (count >= AF_THR);
        almost_empty = (count <= AE_THR);
    end

    // A write into a full FIFO still goes through when a read frees the head slot.
    always_comb begin
        wr_accept = w_en && (!full || r_en);
        rd_accept = r_en && !empty;
    end

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_accept && !flush) begin
            mem[wr_idx] <= data_in;
        end
    end

    // Pointer update; flush wins over any same-edge read or write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Sticky error flags, cleared only by reset or flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (w_en && full && !r_en) begin
                overflow <= 1'b1;
            end
            if (r_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is visible without a read; meaningless while empty.
            assign data_out = mem[rd_idx];
        end else begin : g_registered
            // Registered read port holds its value until the next accepted read.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_out <= '0;
                end else if (rd_accept && !flush) begin
                    data_out <= mem[rd_idx];
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb_sync_fifo_flags: directed bench for a registered-read instance and an FWFT
// instance of sync_fifo_flags, both DEPTH=8, AF_LEVEL=6, AE_LEVEL=2.
module tb_sync_fifo_flags;

    logic       clk;
    logic       rst;

    logic       flush_a, w_en_a, r_en_a;
    logic [7:0] data_in_a, data_out_a;
    logic       full_a, empty_a, af_a, ae_a, ov_a, uf_a;
    logic [3:0] count_a;

    logic       flush_b, w_en_b, r_en_b;
    logic [7:0] data_in_b, data_out_b;
    logic       full_b, empty_b, af_b, ae_b, ov_b, uf_b;
    logic [3:0] count_b;

    int         checks = 0;
    int         errors = 0;
    logic       rd_expect = 1'b0;
    logic [7:0] sb_q[$];

    sync_fifo_flags #(.DATA_WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(0)) dut_a (
        .clk(clk), .rst(rst), .flush(flush_a), .w_en(w_en_a), .r_en(r_en_a),
        .data_in(data_in_a), .data_out(data_out_a), .full(full_a), .empty(empty_a),
        .almost_full(af_a), .almost_empty(ae_a), .count(count_a),
        .overflow(ov_a), .underflow(uf_a)
    );

    sync_fifo_flags #(.DATA_WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1)) dut_b (
        .clk(clk), .rst(rst), .flush(flush_b), .w_en(w_en_b), .r_en(r_en_b),
        .data_in(data_in_b), .data_out(data_out_b), .full(full_b), .empty(empty_b),
        .almost_full(af_b), .almost_empty(ae_b), .count(count_b),
        .overflow(ov_b), .underflow(uf_b)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Status of the registered-read instance, flags modelled from the expected count.
    task automatic check_status_a(input string name, input int c);
        check_output({name, " count"}, 32'(count_a), 32'(c));
        check_output({name, " full"}, 32'(full_a), 32'(c == 8));
        check_output({name, " empty"}, 32'(empty_a), 32'(c == 0));
        check_output({name, " almost_full"}, 32'(af_a), 32'(c >= 6));
        check_output({name, " almost_empty"}, 32'(ae_a), 32'(c <= 2));
    endtask

    // One cycle of stimulus on the registered-read instance; expected read data goes to the scoreboard.
    task automatic apply_stimulus(input logic fl, input logic w, input logic r, input logic [7:0] d,
                                  input logic exp_rd, input logic [7:0] exp_d);
        flush_a   = fl;
        w_en_a    = w;
        r_en_a    = r;
        data_in_a = d;
        rd_expect = exp_rd;
        if (exp_rd) sb_q.push_back(exp_d);
        @(posedge clk);
        @(negedge clk);
        flush_a   = 1'b0;
        w_en_a    = 1'b0;
        r_en_a    = 1'b0;
        rd_expect = 1'b0;
    endtask

    // One cycle of stimulus on the FWFT instance.
    task automatic apply_stimulus_b(input logic fl, input logic w, input logic r, input logic [7:0] d);
        flush_b   = fl;
        w_en_b    = w;
        r_en_b    = r;
        data_in_b = d;
        @(posedge clk);
        @(negedge clk);
        flush_b   = 1'b0;
        w_en_b    = 1'b0;
        r_en_b    = 1'b0;
    endtask

    // Scoreboard monitor: after each edge that sampled an expected read, compare data_out with the queue head.
    initial begin
        logic       fire;
        logic [7:0] exp;
        forever begin
            @(posedge clk);
            fire = rd_expect;
            @(negedge clk);
            if (fire) begin
                if (sb_q.size() == 0) begin
                    check_output("sb underrun", 32'd1, 32'd0);
                end else begin
                    exp = sb_q.pop_front();
                    check_output("sb read data", 32'(data_out_a), 32'(exp));
                end
            end
        end
    end

    // Hard time limit so the run always terminates.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence.
    initial begin
        logic [7:0] rnd;
        rst = 1'b1;
        flush_a = 0; w_en_a = 0; r_en_a = 0; data_in_a = 0;
        flush_b = 0; w_en_b = 0; r_en_b = 0; data_in_b = 0;
        @(negedge clk);
        check_status_a("reset", 0);
        check_output("reset overflow", 32'(ov_a), 32'd0);
        check_output("reset underflow", 32'(uf_a), 32'd0);
        check_output("reset data_out", 32'(data_out_a), 32'd0);
        rst = 1'b0;

        $display("[TB] fill 0x01..0x08 then overflow");
        for (int k = 1; k <= 8; k++) begin
            apply_stimulus(0, 1, 0, 8'(k), 0, 8'h00);
            check_status_a($sformatf("fill %0d", k), k);
        end
        apply_stimulus(0, 1, 0, 8'h09, 0, 8'h00);
        check_status_a("overflow write", 8);
        check_output("overflow flag", 32'(ov_a), 32'd1);

        $display("[TB] drain and underflow");
        for (int k = 1; k <= 8; k++) begin
            apply_stimulus(0, 0, 1, 8'h00, 1, 8'(k));
            check_status_a($sformatf("drain %0d", k), 8 - k);
        end
        apply_stimulus(0, 0, 1, 8'h00, 0, 8'h00);
        check_output("underflow flag", 32'(uf_a), 32'd1);
        check_output("data_out hold", 32'(data_out_a), 32'h08);
        check_output("overflow sticky", 32'(ov_a), 32'd1);

        apply_stimulus(1, 0, 0, 8'h00, 0, 8'h00);
        check_status_a("flush a", 0);
        check_output("flush overflow", 32'(ov_a), 32'd0);
        check_output("flush underflow", 32'(uf_a), 32'd0);

        $display("[TB] simultaneous read/write when full");
        for (int k = 0; k < 8; k++) apply_stimulus(0, 1, 0, 8'(8'h10 + k), 0, 8'h00);
        check_status_a("refill", 8);
        apply_stimulus(0, 1, 1, 8'h18, 1, 8'h10);
        check_status_a("rw full", 8);
        check_output("rw full overflow", 32'(ov_a), 32'd0);
        for (int k = 1; k <= 8; k++) apply_stimulus(0, 0, 1, 8'h00, 1, 8'(8'h10 + k));
        check_status_a("drain after rw", 0);

        $display("[TB] simultaneous read/write when empty");
        apply_stimulus(0, 1, 1, 8'h5A, 0, 8'h00);
        check_status_a("rw empty", 1);
        check_output("rw empty underflow", 32'(uf_a), 32'd1);
        apply_stimulus(0, 0, 1, 8'h00, 1, 8'h5A);
        check_status_a("rw empty readback", 0);

        $display("[TB] wrap-around pairs");
        for (int k = 0; k < 40; k++) begin
            rnd = 8'($urandom);
            apply_stimulus(0, 1, 0, rnd, 0, 8'h00);
            check_output("wrap count after write", 32'(count_a), 32'd1);
            apply_stimulus(0, 0, 1, 8'h00, 1, rnd);
            check_output("wrap count after read", 32'(count_a), 32'd0);
        end
        apply_stimulus(0, 1, 0, 8'hC3, 0, 8'h00);
        apply_stimulus(0, 0, 1, 8'h00, 1, 8'hC3);

        $display("[TB] FWFT instance");
        check_output("fwft reset empty", 32'(empty_b), 32'd1);
        check_output("fwft reset count", 32'(count_b), 32'd0);
        apply_stimulus_b(0, 1, 0, 8'hA5);
        check_output("fwft head", 32'(data_out_b), 32'hA5);
        check_output("fwft empty after write", 32'(empty_b), 32'd0);
        check_output("fwft count after write", 32'(count_b), 32'd1);
        apply_stimulus_b(0, 0, 0, 8'h00);
        check_output("fwft head held", 32'(data_out_b), 32'hA5);
        apply_stimulus_b(0, 0, 1, 8'h00);
        check_output("fwft empty after pop", 32'(empty_b), 32'd1);
        apply_stimulus_b(0, 0, 1, 8'h00);
        check_output("fwft underflow", 32'(uf_b), 32'd1);
        for (int k = 0; k < 9; k++) apply_stimulus_b(0, 1, 0, 8'(8'h30 + k));
        check_output("fwft full", 32'(full_b), 32'd1);
        check_output("fwft overflow", 32'(ov_b), 32'd1);
        check_output("fwft head after fill", 32'(data_out_b), 32'h30);
        apply_stimulus_b(1, 1, 0, 8'h77);
        check_output("fwft flush count", 32'(count_b), 32'd0);
        check_output("fwft flush empty", 32'(empty_b), 32'd1);
        check_output("fwft flush overflow", 32'(ov_b), 32'd0);
        check_output("fwft flush underflow", 32'(uf_b), 32'd0);

        $display("[TB] reset mid-burst");
        apply_stimulus_b(0, 0, 1, 8'h00);
        check_output("fwft underflow before rst", 32'(uf_b), 32'd1);
        w_en_a = 1'b1; data_in_a = 8'hE1;
        w_en_b = 1'b1; data_in_b = 8'hE2;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_status_a("async reset", 0);
        check_output("async reset overflow", 32'(ov_a), 32'd0);
        check_output("async reset underflow", 32'(uf_a), 32'd0);
        check_output("async reset data_out", 32'(data_out_a), 32'd0);
        check_output("fwft async reset count", 32'(count_b), 32'd0);
        check_output("fwft async reset empty", 32'(empty_b), 32'd1);
        check_output("fwft async reset almost_empty", 32'(ae_b), 32'd1);
        check_output("fwft async reset underflow", 32'(uf_b), 32'd0);
        @(negedge clk);
        w_en_a = 1'b0;
        w_en_b = 1'b0;
        rst = 1'b0;
        apply_stimulus(0, 0, 0, 8'h00, 0, 8'h00);
        apply_stimulus(0, 0, 0, 8'h00, 0, 8'h00);
        check_status_a("after reset release", 0);
        check_output("scoreboard drained", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
